// File: rtl/mem_types_pkg.sv
// Shared widths and state encoding for the cache-line to burst adaptor.
package mem_types_pkg;
    localparam int LINE_W      = 256;
    localparam int BEAT_W      = 64;
    localparam int BEATS       = 4;
    localparam int ADDR_W      = 32;
    localparam int OFFSET_BITS = 5;
    localparam int CNT_W       = $clog2(BEATS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } adaptor_state_t;

    // Clear the byte offset so bursts always start on a line boundary.
    function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'((1 << OFFSET_BITS) - 1);
    endfunction
endpackage

// File: rtl/cacheline_adaptor_if.sv
// Line-side and burst-side signals of the adaptor; master is the adaptor itself.
interface cacheline_adaptor_if;
    import mem_types_pkg::*;

    logic [LINE_W-1:0] line_i;
    logic [LINE_W-1:0] line_o;
    logic [ADDR_W-1:0] address_i;
    logic              read_i;
    logic              write_i;
    logic              resp_o;
    logic [BEAT_W-1:0] burst_i;
    logic [BEAT_W-1:0] burst_o;
    logic [ADDR_W-1:0] address_o;
    logic              read_o;
    logic              write_o;
    logic              resp_i;

    modport master (
        input  line_i, address_i, read_i, write_i, burst_i, resp_i,
        output line_o, resp_o, burst_o, address_o, read_o, write_o
    );

    modport slave (
        output line_i, address_i, read_i, write_i, burst_i, resp_i,
        input  line_o, resp_o, burst_o, address_o, read_o, write_o
    );
endinterface

// File: rtl/cacheline_adaptor.sv
// Splits 256-bit line reads/writes into four 64-bit memory beats, lowest beat first.
module cacheline_adaptor
    import mem_types_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    cacheline_adaptor_if.master bus
);
    adaptor_state_t state, state_nxt;

    logic [BEATS-1:0][BEAT_W-1:0] line_buf;
    logic [ADDR_W-1:0]            addr_buf;
    logic [CNT_W-1:0]             cnt;
    logic                         last_beat;

    assign last_beat = bus.resp_i && (cnt == CNT_W'(BEATS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.write_i)     state_nxt = WRITE;
                else if (bus.read_i) state_nxt = READ;
            end
            READ:    if (last_beat) state_nxt = DONE;
            WRITE:   if (last_beat) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.read_o  = (state == READ);
        bus.write_o = (state == WRITE);
        bus.resp_o  = (state == DONE);
    end

    // cnt wraps back to 0 naturally on the last beat, so DONE always exits with cnt == 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_buf <= '0;
            addr_buf <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.write_i) begin
                        line_buf <= bus.line_i;
                        addr_buf <= align_addr(bus.address_i);
                        cnt      <= '0;
                    end else if (bus.read_i) begin
                        addr_buf <= align_addr(bus.address_i);
                        cnt      <= '0;
                    end
                end
                READ: begin
                    if (bus.resp_i) begin
                        line_buf[cnt] <= bus.burst_i;
                        cnt           <= cnt + 1'b1;
                    end
                end
                WRITE: begin
                    if (bus.resp_i) cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.line_o    = line_buf;
    assign bus.burst_o   = line_buf[cnt];
    assign bus.address_o = addr_buf;

    a_no_dual_req: assert property (@(posedge clk) disable iff (rst)
        (state == IDLE) |-> !(bus.read_i && bus.write_i));
endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench: expected lines/beats/addresses queued at request time, checked at output.
module tb_cacheline_adaptor;
    import mem_types_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [LINE_W-1:0] exp_line_q[$];
    logic [BEAT_W-1:0] exp_beat_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];

    cacheline_adaptor_if bus ();

    cacheline_adaptor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One line transaction: request in the next cycle, then beats follow pat[0..plen-1].
    // Ends in the DONE cycle with the request still held, as a real requester would.
    task automatic xfer(input bit is_wr, input logic [ADDR_W-1:0] addr,
                        input logic [LINE_W-1:0] data, input logic [15:0] pat,
                        input int plen, input bit scramble);
        logic [ADDR_W-1:0] al;
        logic [LINE_W-1:0] dv;
        logic [BEAT_W-1:0] eb;
        int beat;
        int wcnt;
        al = addr & 32'hFFFF_FFE0;
        dv = data;
        exp_addr_q.push_back(al);
        if (is_wr) for (int k = 0; k < BEATS; k++) exp_beat_q.push_back(dv[64*k +: 64]);
        else exp_line_q.push_back(dv);

        @(negedge clk);
        total++;
        if (bus.resp_o !== 1'b0 || bus.read_o !== 1'b0 || bus.write_o !== 1'b0) begin
            bad++;
            $display("FAIL idle_before_req: resp=%b rd=%b wr=%b want 0 0 0",
                     bus.resp_o, bus.read_o, bus.write_o);
        end
        bus.read_i    = ~is_wr;
        bus.write_i   = is_wr;
        bus.address_i = addr;
        bus.line_i    = is_wr ? data : {8{$urandom()}};
        @(negedge clk);
        if (scramble) begin
            bus.address_i = ~addr;
            bus.line_i    = ~data;
        end
        total++;
        if (bus.address_o !== al) begin
            bad++;
            $display("FAIL addr_capture: got %h want %h", bus.address_o, al);
        end
        beat = 0;
        wcnt = 0;
        for (int i = 0; i < plen; i++) begin
            total++;
            if (bus.read_o !== ~is_wr || bus.write_o !== is_wr || bus.resp_o !== 1'b0) begin
                bad++;
                $display("FAIL req_held cyc%0d: rd=%b wr=%b resp=%b", i,
                         bus.read_o, bus.write_o, bus.resp_o);
            end
            if (bus.write_o === 1'b1) wcnt++;
            if (is_wr && pat[i]) begin
                eb = exp_beat_q.pop_front();
                total++;
                if (bus.burst_o !== eb) begin
                    bad++;
                    $display("FAIL burst_o beat%0d: got %h want %h", beat, bus.burst_o, eb);
                end
            end
            bus.resp_i  = pat[i];
            bus.burst_i = (pat[i] && !is_wr) ? dv[64*beat +: 64] : {$urandom(), $urandom()};
            if (pat[i]) beat++;
            @(negedge clk);
        end
        bus.resp_i = 1'b0;
        total++;
        if (bus.resp_o !== 1'b1 || bus.read_o !== 1'b0 || bus.write_o !== 1'b0) begin
            bad++;
            $display("FAIL done_cycle: resp=%b rd=%b wr=%b want 1 0 0",
                     bus.resp_o, bus.read_o, bus.write_o);
        end
        al = exp_addr_q.pop_front();
        total++;
        if (bus.address_o !== al) begin
            bad++;
            $display("FAIL addr_at_resp: got %h want %h", bus.address_o, al);
        end
        if (is_wr) begin
            total++;
            if (wcnt != plen) begin
                bad++;
                $display("FAIL write_o_cycles: got %0d want %0d", wcnt, plen);
            end
        end else begin
            dv = exp_line_q.pop_front();
            total++;
            if (bus.line_o !== dv) begin
                bad++;
                $display("FAIL line_o: got %h want %h", bus.line_o, dv);
            end
        end
    endtask

    task automatic drop_req();
        @(negedge clk);
        total++;
        if (bus.resp_o !== 1'b0) begin
            bad++;
            $display("FAIL resp_single_pulse: got %b want 0", bus.resp_o);
        end
        bus.read_i  = 1'b0;
        bus.write_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.line_i = '0; bus.address_i = '0; bus.read_i = 1'b0; bus.write_i = 1'b0;
        bus.burst_i = '0; bus.resp_i = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({bus.line_o, bus.burst_o, bus.address_o, bus.read_o, bus.write_o, bus.resp_o} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: rd=%b wr=%b resp=%b addr=%h", bus.read_o,
                     bus.write_o, bus.resp_o, bus.address_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_idle_resp();
        for (int i = 0; i < 3; i++) begin
            bus.resp_i  = 1'b1;
            bus.burst_i = 64'hDEAD_BEEF_0000_0000 | 64'(i);
            @(negedge clk);
            total++;
            if (bus.read_o !== 1'b0 || bus.write_o !== 1'b0 || bus.resp_o !== 1'b0 ||
                bus.line_o !== '0) begin
                bad++;
                $display("FAIL idle_resp_ignored: rd=%b wr=%b resp=%b", bus.read_o,
                         bus.write_o, bus.resp_o);
            end
        end
        bus.resp_i = 1'b0;
    endtask

    task automatic test_read();
        xfer(1'b0, 32'h0000_1234, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, 16'h000F, 4, 1'b0);
        drop_req();
    endtask

    task automatic test_write();
        xfer(1'b1, 32'h8000_0040, {64'hD, 64'hC, 64'hB, 64'hA}, 16'h000F, 4, 1'b0);
        drop_req();
    endtask

    task automatic test_stall();
        xfer(1'b0, 32'h0000_2A1F, {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
             64'h5555_AAAA_5555_AAAA, 64'hA5A5_0F0F_F0F0_5A5A}, 16'h0059, 7, 1'b0);
        drop_req();
    endtask

    task automatic test_back_to_back();
        xfer(1'b1, 32'h0000_0100, {64'h44, 64'h33, 64'h22, 64'h11}, 16'h000F, 4, 1'b0);
        xfer(1'b0, 32'h0000_0F7C, {64'h9, 64'h8, 64'h7, 64'h6}, 16'h000F, 4, 1'b0);
        drop_req();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.read_i = 1'b1;
        bus.address_i = 32'h0000_3000;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            bus.resp_i  = 1'b1;
            bus.burst_i = 64'hBAD0_0000_0000_0000 | 64'(i);
            @(negedge clk);
        end
        bus.resp_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({bus.line_o, bus.burst_o, bus.address_o, bus.read_o, bus.write_o, bus.resp_o} !== '0) begin
            bad++;
            $display("FAIL reset_mid_read: rd=%b resp=%b addr=%h line_nonzero=%b",
                     bus.read_o, bus.resp_o, bus.address_o, |bus.line_o);
        end
        bus.read_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        xfer(1'b0, 32'h0000_3008, {64'hD4, 64'hC3, 64'hB2, 64'hA1}, 16'h000F, 4, 1'b0);
        drop_req();
    endtask

    task automatic test_stability();
        xfer(1'b1, 32'h1234_5660, {64'h4444_0000_0000_0004, 64'h3333_0000_0000_0003,
             64'h2222_0000_0000_0002, 64'h1111_0000_0000_0001}, 16'h0035, 6, 1'b1);
        drop_req();
        xfer(1'b0, 32'h0BAD_C0DE, {64'h1, 64'h2, 64'h3, 64'h4}, 16'h000F, 4, 1'b1);
        drop_req();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_idle_resp();
        test_read();
        test_write();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_stability();
        total++;
        if (exp_line_q.size() != 0 || exp_beat_q.size() != 0 || exp_addr_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: lines=%0d beats=%0d addrs=%0d want 0 0 0",
                     exp_line_q.size(), exp_beat_q.size(), exp_addr_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
